// File: rtl/pool_window_gather.sv
// pool_window_gather: buffers one row and emits non-overlapping 2x2 windows (stride 2) on a valid/ready slot.
// Define POOL_WIN_IDX_EN to add win_row/win_col pooled-output coordinates.
module pool_window_gather #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    localparam int WR_W  = (IMG_H > 2) ? $clog2(IMG_H / 2) : 1,
    localparam int WC_W  = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                win_valid,
    input  logic                win_ready,
    output logic [4*DATA_W-1:0] win_data,
    output logic                frame_done
`ifdef POOL_WIN_IDX_EN
    ,
    output logic [WR_W-1:0]     win_row,
    output logic [WC_W-1:0]     win_col
`endif
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [DATA_W-1:0]   line_buf [IMG_W];
    logic [4*DATA_W-1:0] win_data_q, win_data_d;
    logic                win_valid_q, win_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                accept, br, last_col, last_row, load;
`ifdef POOL_WIN_IDX_EN
    logic [WR_W-1:0]     win_row_q, win_row_d;
    logic [WC_W-1:0]     win_col_q, win_col_d;
`endif

    always_comb begin
        br           = row_q[0] && col_q[0];
        last_col     = col_q == CW'(IMG_W - 1);
        last_row     = row_q == RW'(IMG_H - 1);
        // only the bottom-right beat can stall; in_ready is held low through reset
        in_ready     = rst_n && !clear && (!br || !win_valid_q || win_ready);
        accept       = in_valid && in_ready;
        load         = accept && br;
        col_d        = clear ? '0 : !accept ? col_q : last_col ? '0 : col_q + CW'(1);
        row_d        = clear ? '0 : !(accept && last_col) ? row_q : last_row ? '0 : row_q + RW'(1);
        hold_d       = (accept && row_q[0] && !col_q[0]) ? in_data : hold_q;
        win_data_d   = load ? {in_data, hold_q, line_buf[col_q], line_buf[col_q - CW'(1)]} : win_data_q;
        win_valid_d  = !clear && (load || (win_valid_q && !win_ready));
        frame_done_d = load && last_row && last_col;
`ifdef POOL_WIN_IDX_EN
        win_row_d    = load ? WR_W'(row_q >> 1) : win_row_q;
        win_col_d    = load ? WC_W'(col_q >> 1) : win_col_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            win_data_q   <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef POOL_WIN_IDX_EN
            win_row_q    <= '0;
            win_col_q    <= '0;
`endif
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            win_data_q   <= win_data_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
`ifdef POOL_WIN_IDX_EN
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !row_q[0])
            line_buf[col_q] <= in_data;
    end

    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign frame_done = frame_done_q;
`ifdef POOL_WIN_IDX_EN
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
`endif
endmodule
